// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - Shared types and helpers for the instruction memory arbiter.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } imem_owner_t;

  // Byte address must be word aligned and fall inside the array.
  function automatic logic imem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < (depth * 4));
  endfunction

endpackage

// File: rtl/imem_rr_grant.sv
// rtl/imem_rr_grant.sv - Two-way fetch/loader grant; IMEM_ARB_RR_EN selects round-robin over fixed priority.
module imem_rr_grant (
`ifdef IMEM_ARB_RR_EN
  input  logic clk_i,
  input  logic rst_i,
`endif
  input  logic if_valid_i,
  input  logic ld_valid_i,
  input  logic ld_lock_i,
  output logic gnt_if_o,
  output logic gnt_ld_o
);

`ifdef IMEM_ARB_RR_EN
  logic last_ld_q;
  logic last_ld_d;

  // Reset value points at LD so the fetch port wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_ld_q <= 1'b1;
    end else begin
      last_ld_q <= last_ld_d;
    end
  end

  always_comb begin
    last_ld_d = last_ld_q;
    if (gnt_if_o || gnt_ld_o) begin
      last_ld_d = gnt_ld_o;
    end
  end
`endif

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_ld_o = 1'b0;
    if (ld_lock_i) begin
      gnt_ld_o = ld_valid_i;
    end else if (if_valid_i && ld_valid_i) begin
`ifdef IMEM_ARB_RR_EN
      gnt_if_o = last_ld_q;
      gnt_ld_o = !last_ld_q;
`else
      gnt_if_o = 1'b1;
`endif
    end else begin
      gnt_if_o = if_valid_i;
      gnt_ld_o = ld_valid_i;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - Fetch/loader arbiter for the single-port instruction memory; IMEM_ARB_RR_EN enables round-robin.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [31:0]   if_req_addr,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,
  output logic          if_rsp_err,
  input  logic          ld_req_valid,
  output logic          ld_req_ready,
  input  logic          ld_req_we,
  input  logic [31:0]   ld_req_addr,
  input  logic [31:0]   ld_req_wdata,
  input  logic          ld_lock,
  output logic          ld_rsp_valid,
  output logic [31:0]   ld_rsp_data,
  output logic          ld_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic        gnt_if;
  logic        gnt_ld;
  logic [31:0] sel_addr;
  logic        addr_ok;

  imem_owner_t owner_q, owner_d;
  logic        err_q, err_d;
  logic        we_q, we_d;

  // Nothing is granted while reset is held.
  imem_rr_grant u_grant (
`ifdef IMEM_ARB_RR_EN
    .clk_i      (clk),
    .rst_i      (rst),
`endif
    .if_valid_i (if_req_valid && !rst),
    .ld_valid_i (ld_req_valid && !rst),
    .ld_lock_i  (ld_lock),
    .gnt_if_o   (gnt_if),
    .gnt_ld_o   (gnt_ld)
  );

  assign if_req_ready = gnt_if;
  assign ld_req_ready = gnt_ld;

  assign sel_addr  = gnt_ld ? ld_req_addr : if_req_addr;
  assign addr_ok   = imem_addr_ok(sel_addr, DEPTH);

  assign mem_en    = (gnt_if || gnt_ld) && addr_ok;
  assign mem_we    = gnt_ld && ld_req_we && addr_ok;
  assign mem_addr  = sel_addr[AW+1:2];
  assign mem_wdata = ld_req_wdata;

  always_comb begin
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    we_d    = 1'b0;
    if (gnt_if) begin
      owner_d = OWN_IF;
      err_d   = !addr_ok;
    end else if (gnt_ld) begin
      owner_d = OWN_LD;
      err_d   = !addr_ok;
      we_d    = ld_req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Gating with rst drops a response that would land in a reset cycle.
  assign if_rsp_valid = (owner_q == OWN_IF) && !rst;
  assign ld_rsp_valid = (owner_q == OWN_LD) && !rst;
  assign if_rsp_err   = if_rsp_valid && err_q;
  assign ld_rsp_err   = ld_rsp_valid && err_q;
  assign if_rsp_data  = (if_rsp_valid && !err_q) ? mem_rdata : 32'h0;
  assign ld_rsp_data  = (ld_rsp_valid && !err_q && !we_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - Randomised scoreboard bench for imem_arbiter (honours IMEM_ARB_RR_EN).
module tb_imem_arbiter;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [31:0]   if_req_addr;
  logic          if_rsp_valid, if_rsp_err;
  logic [31:0]   if_rsp_data;
  logic          ld_req_valid, ld_req_ready, ld_req_we, ld_lock;
  logic [31:0]   ld_req_addr, ld_req_wdata;
  logic          ld_rsp_valid, ld_rsp_err;
  logic [31:0]   ld_rsp_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
    .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata), .ld_lock(ld_lock),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        ld_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
`ifdef IMEM_ARB_RR_EN
  logic        last_ld = 1'b1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first single-port array.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        mem_rdata        <= mem_wdata;
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit addr_good(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(DEPTH * 4));
  endfunction

  task automatic step(input bit r, input bit ifv, input logic [31:0] ifa,
                      input bit ldv, input bit we, input logic [31:0] lda,
                      input logic [31:0] wd, input bit lock);
    bit         exp_if, exp_ld, ok;
    logic [31:0] a;
    int         idx;
    rsp_t       e;
    @(posedge clk);
    #1;
    rst = r; if_req_valid = ifv; if_req_addr = ifa;
    ld_req_valid = ldv; ld_req_we = we; ld_req_addr = lda; ld_req_wdata = wd; ld_lock = lock;
    #1;
    exp_if = 1'b0;
    exp_ld = 1'b0;
    if (r) begin
      if_q.delete();
      ld_q.delete();
`ifdef IMEM_ARB_RR_EN
      last_ld = 1'b1;
`endif
      chk1("rst_if_rsp_valid", if_rsp_valid, 1'b0);
      chk1("rst_ld_rsp_valid", ld_rsp_valid, 1'b0);
      chk32("rst_if_rsp_data", if_rsp_data, 32'h0);
      chk1("rst_ld_rsp_err", ld_rsp_err, 1'b0);
    end else if (lock) begin
      exp_ld = ldv;
    end else if (ifv && ldv) begin
`ifdef IMEM_ARB_RR_EN
      if (last_ld) exp_if = 1'b1; else exp_ld = 1'b1;
`else
      exp_if = 1'b1;
`endif
    end else begin
      exp_if = ifv;
      exp_ld = ldv;
    end
`ifdef IMEM_ARB_RR_EN
    if (exp_if || exp_ld) last_ld = exp_ld;
`endif
    chk1("if_req_ready", if_req_ready, exp_if);
    chk1("ld_req_ready", ld_req_ready, exp_ld);
    a   = exp_ld ? lda : ifa;
    ok  = addr_good(a);
    idx = int'(a / 4) % DEPTH;
    chk1("mem_en", mem_en, (exp_if || exp_ld) && ok);
    chk1("mem_we", mem_we, exp_ld && we && ok);
    if ((exp_if || exp_ld) && ok) chk32("mem_addr", 32'(mem_addr), 32'(idx));
    e.err = !ok;
    e.due = cyc + 1;
    e.data = 32'h0;
    if (exp_if) begin
      if (ok) e.data = ref_mem[idx];
      if_q.push_back(e);
    end else if (exp_ld) begin
      if (ok && !we) e.data = ref_mem[idx];
      if (ok && we) ref_mem[idx] = wd;
      ld_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (if_rsp_valid) begin
      if (if_q.size() == 0) begin
        total++; bad++;
        $display("FAIL if_rsp_unexpected: got valid=1 expected valid=0 (cycle %0d)", cyc);
      end else begin
        e = if_q.pop_front();
        chk32("if_rsp_cycle", 32'(cyc), 32'(e.due));
        chk32("if_rsp_data", if_rsp_data, e.data);
        chk1("if_rsp_err", if_rsp_err, e.err);
      end
    end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
      total++; bad++;
      $display("FAIL if_rsp_missing: got valid=0 expected valid=1 (cycle %0d)", cyc);
      void'(if_q.pop_front());
    end
    if (ld_rsp_valid) begin
      if (ld_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ld_rsp_unexpected: got valid=1 expected valid=0 (cycle %0d)", cyc);
      end else begin
        e = ld_q.pop_front();
        chk32("ld_rsp_cycle", 32'(cyc), 32'(e.due));
        chk32("ld_rsp_data", ld_rsp_data, e.data);
        chk1("ld_rsp_err", ld_rsp_err, e.err);
      end
    end else if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
      total++; bad++;
      $display("FAIL ld_rsp_missing: got valid=0 expected valid=1 (cycle %0d)", cyc);
      void'(ld_q.pop_front());
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0; ld_req_valid = 1'b0;
    ld_req_we = 1'b0; ld_req_addr = '0; ld_req_wdata = '0; ld_lock = 1'b0; mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end

    for (int i = 0; i < 3; i++) step(1, 1, 32'h10, 1, 0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 4; i++) step(0, 1, 32'(4 * i), 1, 0, 32'(32'h100 + 4 * i), 32'h0, 0);

    step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0);
    idle();

    step(0, 1, 32'h8, 1, 1, 32'h40, 32'hDEADBEEF, 1);
    step(0, 1, 32'hC, 1, 0, 32'h40, 32'h0, 1);
    idle();

    step(0, 1, 32'h2, 0, 0, 32'h0, 32'h0, 0);
    step(0, 1, 32'h1000, 0, 0, 32'h0, 32'h0, 0);
    idle();

    step(0, 1, 32'h20, 0, 0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, b,
           $urandom, $urandom_range(0, 7) == 0);
    end

    idle();
    idle();
    chk32("if_q_drained", 32'(if_q.size()), 32'h0);
    chk32("ld_q_drained", 32'(ld_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
